// File: rtl/gpio_poll_pkg.sv
// Shared types and constants for the GPIO poll controller.
// State encodings, GPIO register map and bus direction values.
package gpio_poll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_e;

    localparam logic [1:0] ADDR_IN_DATA  = 2'd0;
    localparam logic [1:0] ADDR_OUT_DATA = 2'd1;
    localparam logic [1:0] ADDR_IO_DATA  = 2'd2;
    localparam logic [1:0] ADDR_IO_DIR   = 2'd3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/gpio_poll_timer.sv
// Poll period down-counter; raises a sticky poll request at each reload.
// Request is held until the sequencer takes it.
module gpio_poll_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             take_i,
    output logic             pend_o
);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             fire;

    always_comb begin
        cnt_d = cnt_q;
        fire  = 1'b0;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (period_i != '0) begin
            if (cnt_q == '0) begin
                fire  = 1'b1;
                cnt_d = period_i - PER_W'(1);
            end else begin
                cnt_d = cnt_q - PER_W'(1);
            end
        end
        // a fresh reload beats a take in the same cycle
        pend_d = enable_i & ((pend_q & ~take_i) | fire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/gpio_poll_ctrl.sv
// GPIO bus-master sequencer: periodic input polling with change interrupt
// plus arbitrated host register writes.
module gpio_poll_ctrl
    import gpio_poll_pkg::*;
#(
    parameter int IN_CH = 8,
    parameter int PER_W = 16,
    parameter int TMO   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PER_W-1:0] poll_period,
    input  logic [IN_CH-1:0] irq_mask,
    input  logic             irq_clr,
    input  logic             wr_req,
    input  logic [1:0]       wr_addr,
    input  logic [31:0]      wr_val,
    output logic             wr_ack,
    output logic [IN_CH-1:0] in_data,
    output logic [IN_CH-1:0] chg_flags,
    output logic             irq,
    output logic             bus_err,
    output logic             g_cs_,
    output logic             g_as_,
    output logic             g_rw,
    output logic [1:0]       g_addr,
    output logic [31:0]      g_wr_data,
    input  logic [31:0]      g_rd_data,
    input  logic             g_rdy_
);

    localparam int TW = $clog2(TMO + 1);

    state_e           state_q, state_d;
    logic             cs_q, cs_d, as_q, as_d, rw_q, rw_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ack_q, ack_d;
    logic [IN_CH-1:0] in_q, in_d, flags_q, flags_d, new_v;
    logic             irq_q, err_q, err_d;
    logic             primed_q, primed_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             poll_pend, take;
    logic             unused_rd;

    assign unused_rd = ^g_rd_data[31:IN_CH];
    assign new_v     = g_rd_data[IN_CH-1:0];

    gpio_poll_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .period_i (poll_period),
        .take_i   (take),
        .pend_o   (poll_pend)
    );

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        as_d     = as_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        in_d     = in_q;
        flags_d  = irq_clr ? '0 : flags_q;
        err_d    = irq_clr ? 1'b0 : err_q;
        primed_d = primed_q;
        tcnt_d   = tcnt_q;
        take     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    cs_d    = 1'b0;
                    as_d    = 1'b0;
                    rw_d    = RW_WRITE;
                    addr_d  = wr_addr;
                    wdata_d = wr_val;
                    tcnt_d  = '0;
                    state_d = ST_ACC;
                end else if (poll_pend) begin
                    cs_d    = 1'b0;
                    as_d    = 1'b0;
                    rw_d    = RW_READ;
                    addr_d  = ADDR_IN_DATA;
                    take    = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (!g_rdy_ || tcnt_q == TW'(TMO - 1)) begin
                    cs_d    = 1'b1;
                    as_d    = 1'b1;
                    rw_d    = RW_READ;
                    ack_d   = (rw_q == RW_WRITE);
                    state_d = ST_DONE;
                    if (g_rdy_) begin
                        err_d = 1'b1;
                    end else if (rw_q == RW_READ) begin
                        // first read after enable only establishes a baseline
                        if (primed_q)
                            flags_d = flags_d | ((new_v ^ in_q) & irq_mask);
                        in_d     = new_v;
                        primed_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (!enable)
            primed_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cs_q     <= 1'b1;
            as_q     <= 1'b1;
            rw_q     <= RW_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            in_q     <= '0;
            flags_q  <= '0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            primed_q <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            as_q     <= as_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            in_q     <= in_d;
            flags_q  <= flags_d;
            irq_q    <= |flags_d;
            err_q    <= err_d;
            primed_q <= primed_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign g_cs_     = cs_q;
    assign g_as_     = as_q;
    assign g_rw      = rw_q;
    assign g_addr    = addr_q;
    assign g_wr_data = wdata_q;
    assign wr_ack    = ack_q;
    assign in_data   = in_q;
    assign chg_flags = flags_q;
    assign irq       = irq_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_gpio_poll_ctrl.sv
// Bench for gpio_poll_ctrl: GPIO slave model, bus-access scoreboard
// and directed polling / write / timeout scenarios.
module tb_gpio_poll_ctrl;

    typedef struct {
        logic        rw;
        logic [1:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] poll_period = '0;
    logic [7:0]  irq_mask = '0;
    logic        irq_clr = 1'b0;
    logic        wr_req = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_val = '0;
    logic        wr_ack;
    logic [7:0]  in_data, chg_flags;
    logic        irq, bus_err;
    logic        g_cs_, g_as_, g_rw;
    logic [1:0]  g_addr;
    logic [31:0] g_wr_data, g_rd_data;
    logic        g_rdy_;

    logic [7:0]  gpio_in = '0;
    logic        stall = 1'b0;
    logic        sb_en = 1'b0;
    acc_t        exp_q[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, n_acc = 0, rd_done = 0;
    int          last_start = 0, prev_start = 0;
    logic        prev_cs = 1'b1;

    always #5 clk = ~clk;

    gpio_poll_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .poll_period (poll_period),
        .irq_mask    (irq_mask),
        .irq_clr     (irq_clr),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_val      (wr_val),
        .wr_ack      (wr_ack),
        .in_data     (in_data),
        .chg_flags   (chg_flags),
        .irq         (irq),
        .bus_err     (bus_err),
        .g_cs_       (g_cs_),
        .g_as_       (g_as_),
        .g_rw        (g_rw),
        .g_addr      (g_addr),
        .g_wr_data   (g_wr_data),
        .g_rd_data   (g_rd_data),
        .g_rdy_      (g_rdy_)
    );

    assign g_rd_data = {24'h0, gpio_in};

    always @(posedge clk or negedge reset)
        if (!reset) g_rdy_ <= 1'b1;
        else g_rdy_ <= !(!g_cs_ && !g_as_ && g_rdy_ && !stall);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial forever begin
        acc_t e;
        @(posedge clk);
        cyc++;
        if (!g_cs_ && !g_as_ && prev_cs) begin
            n_acc++;
            prev_start = last_start;
            last_start = cyc;
            if (sb_en) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("acc_rw", g_rw, e.rw);
                    chk("acc_addr", g_addr, e.addr);
                    if (!e.rw) chk("acc_wdata", g_wr_data, e.data);
                end
            end
        end
        if (!g_cs_ && !g_rdy_ && g_rw) rd_done++;
        prev_cs = g_cs_;
    end

    task automatic wait_rd(input int budget);
        int t0 = rd_done;
        int n = 0;
        while (rd_done == t0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("rd_wait", rd_done != t0, 1);
    endtask

    task automatic pulse_clr;
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] v,
                            output int lat);
        int n = 0;
        wr_req = 1'b1;
        wr_addr = a;
        wr_val = v;
        while (!wr_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        wr_req = 1'b0;
        chk("wr_ack", wr_ack, 1);
        lat = n;
        @(negedge clk);
        chk("ack_pulse", wr_ack, 0);
    endtask

    initial begin
        int lat, n0, ws;
        repeat (3) @(negedge clk);
        chk("rst_cs", g_cs_, 1);
        chk("rst_as", g_as_, 1);
        chk("rst_rw", g_rw, 1);
        chk("rst_addr", g_addr, 0);
        chk("rst_wdata", g_wr_data, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_in", in_data, 0);
        chk("rst_flags", chg_flags, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", bus_err, 0);
        reset = 1'b1;
        @(negedge clk);

        poll_period = 16'd10;
        irq_mask = 8'hFF;
        gpio_in = 8'h00;
        enable = 1'b1;
        wait_rd(30);
        @(negedge clk);
        chk("prime_flags", chg_flags, 0);
        chk("prime_in", in_data, 8'h00);
        gpio_in = 8'h05;
        wait_rd(30);
        chk("period", last_start - prev_start, 10);
        chk("chg5_flags", chg_flags, 8'h05);
        chk("chg5_irq", irq, 1);
        chk("chg5_in", in_data, 8'h05);

        n0 = 0;
        while (g_cs_ && n0 < 30) begin
            @(negedge clk);
            n0++;
        end
        chk("acc_seen", g_cs_, 0);
        reset = 1'b0;
        #1;
        chk("midrst_cs", g_cs_, 1);
        chk("midrst_as", g_as_, 1);
        chk("midrst_irq", irq, 0);
        chk("midrst_err", bus_err, 0);
        chk("midrst_flags", chg_flags, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_rd(30);
        @(negedge clk);
        chk("reprime_flags", chg_flags, 0);
        chk("reprime_in", in_data, 8'h05);

        gpio_in = 8'h07;
        wait_rd(30);
        chk("chg2_flags", chg_flags, 8'h02);
        chk("chg2_irq", irq, 1);
        pulse_clr;
        chk("clr_flags", chg_flags, 0);
        chk("clr_irq", irq, 0);

        irq_mask = 8'h01;
        gpio_in = 8'h00;
        wait_rd(30);
        pulse_clr;
        gpio_in = 8'h06;
        wait_rd(30);
        chk("mask_flags", chg_flags, 0);
        chk("mask_irq", irq, 0);
        chk("mask_in", in_data, 8'h06);

        enable = 1'b0;
        repeat (6) @(negedge clk);
        sb_en = 1'b1;
        exp_q.push_back('{1'b0, 2'd1, 32'h0000_00A5});
        exp_q.push_back('{1'b1, 2'd0, 32'h0});
        enable = 1'b1;
        @(negedge clk);
        do_write(2'd1, 32'h0000_00A5, lat);
        ws = last_start;
        chk("prio_lat", lat, 3);
        wait_rd(20);
        enable = 1'b0;
        chk("prio_slot", last_start - ws, 4);
        repeat (5) @(negedge clk);
        chk("prio_drain", exp_q.size(), 0);

        stall = 1'b1;
        exp_q.push_back('{1'b0, 2'd2, 32'h0000_005A});
        do_write(2'd2, 32'h0000_005A, lat);
        chk("tmo_lat", lat, 16);
        chk("tmo_err", bus_err, 1);
        pulse_clr;
        chk("tmo_clr", bus_err, 0);
        stall = 1'b0;

        poll_period = 16'd0;
        enable = 1'b1;
        n0 = n_acc;
        repeat (100) @(negedge clk);
        chk("p0_noacc", n_acc - n0, 0);
        exp_q.push_back('{1'b0, 2'd3, 32'hDEAD_BEEF});
        do_write(2'd3, 32'hDEAD_BEEF, lat);
        chk("p0_wr_lat", lat, 3);
        poll_period = 16'd10;
        enable = 1'b0;
        n0 = n_acc;
        repeat (100) @(negedge clk);
        chk("dis_noacc", n_acc - n0, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
